// File: rtl/gemm_pkg.sv
// gemm_pkg: shared operand-loader defaults and loader state encoding.
// Optional framing checks in the loader are enabled by GEMM_LOADER_LAST_CHECK_EN.
package gemm_pkg;
   localparam int DATA_WIDTH_D    = 32;
   localparam int MATRIX_WIDTH_D  = 4;
   localparam int MATRIX_HEIGHT_D = 4;
   typedef enum logic [2:0] {
      LD_ALPHA,
      LD_BETA,
      LD_A,
      LD_B,
      LD_C,
      HOLD,
      DRAIN
   } ld_state_t;
endpackage

// File: rtl/gemm_idx_counter.sv
// gemm_idx_counter: matrix element index counter that wraps at COUNT-1.
// Ports: i_clk, i_rst (sync, active high), i_clr (sync clear), i_en (advance),
//        o_idx (current element index), o_tc (index is COUNT-1).
module gemm_idx_counter #(
   parameter  int COUNT = 16,
   localparam int W     = COUNT > 1 ? $clog2(COUNT) : 1
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_clr,
   input  logic         i_en,
   output logic [W-1:0] o_idx,
   output logic         o_tc
);
   logic [W-1:0] r_idx;
   assign o_idx = r_idx;
   assign o_tc  = r_idx == W'(COUNT - 1);
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) r_idx <= '0;
      else if (i_en) r_idx <= o_tc ? '0 : r_idx + W'(1);
   end
endmodule

// File: rtl/gemm_operand_loader.sv
// gemm_operand_loader: deserialises alpha, beta, A, B, C from a word stream into GEMM operands.
// Ports: iclk, irst (sync, active high); s_data/s_valid/s_ready/s_last inbound stream;
//        alpha, beta, a_matrix, b_matrix, c_matrix operands; op_valid/op_ready handoff;
//        frame_err sticky framing error.
// Macro GEMM_LOADER_LAST_CHECK_EN enables s_last framing checks and the DRAIN state.
module gemm_operand_loader
   import gemm_pkg::*;
#(
   parameter int DATA_WIDTH    = DATA_WIDTH_D,
   parameter int MATRIX_WIDTH  = MATRIX_WIDTH_D,
   parameter int MATRIX_HEIGHT = MATRIX_HEIGHT_D
) (
   input  logic                  iclk,
   input  logic                  irst,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic                  s_last,
   output logic [DATA_WIDTH-1:0] alpha,
   output logic [DATA_WIDTH-1:0] beta,
   output logic [DATA_WIDTH-1:0] a_matrix [0:MATRIX_HEIGHT-1][0:MATRIX_WIDTH-1],
   output logic [DATA_WIDTH-1:0] b_matrix [0:MATRIX_HEIGHT-1][0:MATRIX_WIDTH-1],
   output logic [DATA_WIDTH-1:0] c_matrix [0:MATRIX_HEIGHT-1][0:MATRIX_WIDTH-1],
   output logic                  op_valid,
   input  logic                  op_ready,
   output logic                  frame_err
);
   localparam int ELEMS = MATRIX_WIDTH * MATRIX_HEIGHT;
   localparam int IW    = ELEMS > 1 ? $clog2(ELEMS) : 1;
   localparam int RW    = MATRIX_HEIGHT > 1 ? $clog2(MATRIX_HEIGHT) : 1;
   localparam int CW    = MATRIX_WIDTH > 1 ? $clog2(MATRIX_WIDTH) : 1;

   ld_state_t             r_state;
   logic                  r_s_ready;
   logic                  r_op_valid;
   logic [DATA_WIDTH-1:0] r_alpha;
   logic [DATA_WIDTH-1:0] r_beta;
   logic [DATA_WIDTH-1:0] r_a [0:MATRIX_HEIGHT-1][0:MATRIX_WIDTH-1];
   logic [DATA_WIDTH-1:0] r_b [0:MATRIX_HEIGHT-1][0:MATRIX_WIDTH-1];
   logic [DATA_WIDTH-1:0] r_c [0:MATRIX_HEIGHT-1][0:MATRIX_WIDTH-1];
   logic                  w_acc;
   logic                  w_abort;
   logic                  w_tc;
   logic [IW-1:0]         w_idx;
   logic [RW-1:0]         w_row;
   logic [CW-1:0]         w_col;

   assign w_acc    = s_valid && r_s_ready;
   assign w_row    = RW'(int'(w_idx) / MATRIX_WIDTH);
   assign w_col    = CW'(int'(w_idx) % MATRIX_WIDTH);
   assign s_ready  = r_s_ready;
   assign op_valid = r_op_valid;
   assign alpha    = r_alpha;
   assign beta     = r_beta;
   assign a_matrix = r_a;
   assign b_matrix = r_b;
   assign c_matrix = r_c;

`ifdef GEMM_LOADER_LAST_CHECK_EN
   logic r_frame_err;
   assign frame_err = r_frame_err;
   // s_last on any word except the final C word cuts the frame short
   assign w_abort   = w_acc && s_last && r_state != DRAIN && !(r_state == LD_C && w_tc);
`else
   logic w_unused_last;
   assign w_unused_last = s_last;
   assign frame_err     = 1'b0;
   assign w_abort       = 1'b0;
`endif

   gemm_idx_counter #(.COUNT(ELEMS)) u_idx (
      .i_clk (iclk),
      .i_rst (irst),
      .i_clr (w_abort),
      .i_en  (w_acc && !w_abort && (r_state == LD_A || r_state == LD_B || r_state == LD_C)),
      .o_idx (w_idx),
      .o_tc  (w_tc)
   );

   always_ff @(posedge iclk) begin
      if (irst) begin
         r_state    <= LD_ALPHA;
         r_s_ready  <= 1'b0;
         r_op_valid <= 1'b0;
         r_alpha    <= '0;
         r_beta     <= '0;
         for (int i = 0; i < MATRIX_HEIGHT; i++)
            for (int j = 0; j < MATRIX_WIDTH; j++) begin
               r_a[i][j] <= '0;
               r_b[i][j] <= '0;
               r_c[i][j] <= '0;
            end
`ifdef GEMM_LOADER_LAST_CHECK_EN
         r_frame_err <= 1'b0;
`endif
      end else begin
         r_s_ready <= 1'b1;
`ifdef GEMM_LOADER_LAST_CHECK_EN
         if (w_abort) begin
            r_state     <= LD_ALPHA;
            r_frame_err <= 1'b1;
         end else
`endif
         case (r_state)
            LD_ALPHA: if (w_acc) begin
               r_alpha <= s_data;
               r_state <= LD_BETA;
            end
            LD_BETA: if (w_acc) begin
               r_beta  <= s_data;
               r_state <= LD_A;
            end
            LD_A: if (w_acc) begin
               r_a[w_row][w_col] <= s_data;
               if (w_tc) r_state <= LD_B;
            end
            LD_B: if (w_acc) begin
               r_b[w_row][w_col] <= s_data;
               if (w_tc) r_state <= LD_C;
            end
            LD_C: if (w_acc) begin
               r_c[w_row][w_col] <= s_data;
               if (w_tc) begin
`ifdef GEMM_LOADER_LAST_CHECK_EN
                  if (!s_last) begin
                     r_state     <= DRAIN;
                     r_frame_err <= 1'b1;
                  end else
`endif
                  begin
                     r_state    <= HOLD;
                     r_op_valid <= 1'b1;
                     r_s_ready  <= 1'b0;
                  end
               end
            end
            HOLD: if (op_ready) begin
               r_state    <= LD_ALPHA;
               r_op_valid <= 1'b0;
            end else r_s_ready <= 1'b0;
`ifdef GEMM_LOADER_LAST_CHECK_EN
            DRAIN: if (w_acc && s_last) r_state <= LD_ALPHA;
`endif
            default: r_state <= LD_ALPHA;
         endcase
      end
   end
endmodule

// File: tb/tb_gemm_operand_loader.sv
// tb_gemm_operand_loader: directed self-checking bench for gemm_operand_loader.
module tb_gemm_operand_loader;
   logic        clk = 1'b0;
   logic        irst;
   logic [31:0] s_data;
   logic        s_valid;
   logic        s_ready;
   logic        s_last;
   logic [31:0] alpha;
   logic [31:0] beta;
   logic [31:0] a_m [0:3][0:3];
   logic [31:0] b_m [0:3][0:3];
   logic [31:0] c_m [0:3][0:3];
   logic        op_valid;
   logic        op_ready;
   logic        frame_err;
   int          tests = 0;
   int          failed = 0;

   always #5 clk = ~clk;

   gemm_operand_loader dut (
      .iclk      (clk),
      .irst      (irst),
      .s_data    (s_data),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_last    (s_last),
      .alpha     (alpha),
      .beta      (beta),
      .a_matrix  (a_m),
      .b_matrix  (b_m),
      .c_matrix  (c_m),
      .op_valid  (op_valid),
      .op_ready  (op_ready),
      .frame_err (frame_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] word_val(input int k, input logic [31:0] al);
      if (k == 1) return al;
      if (k == 2) return 32'd1;
      if (k <= 18) return 32'(k - 3);
      if (k <= 34) return 32'((k - 19) / 4 == (k - 19) % 4);
      return 32'd0;
   endfunction

   task automatic send(input logic [31:0] d, input logic l);
      int n = 0;
      s_data  = d;
      s_valid = 1'b1;
      s_last  = l;
      while (!s_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!s_ready) check("s_ready_timeout", 32'(s_ready), 32'd1);
      @(negedge clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic send_frame(input logic [31:0] al, input int nwords, input int last_at, input bit gap);
      for (int k = 1; k <= nwords; k++) begin
         if (k == 50 && last_at == 50) check("pre_valid", 32'(op_valid), 32'd0);
         send(word_val(k, al), k == last_at);
         if (k == 50 && nwords > 50) check("drain_no_valid", 32'(op_valid), 32'd0);
         if (gap) @(negedge clk);
      end
   endtask

   task automatic check_frame(input logic [31:0] al);
      check("alpha", alpha, al);
      check("beta", beta, 32'd1);
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            check("a_mat", a_m[i][j], 32'(i * 4 + j));
            check("b_mat", b_m[i][j], 32'(i == j));
            check("c_mat", c_m[i][j], 32'd0);
         end
   endtask

   task automatic release_hold();
      op_ready = 1'b1;
      @(negedge clk);
      op_ready = 1'b0;
      check("rel_s_ready", 32'(s_ready), 32'd1);
      check("rel_op_valid", 32'(op_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      irst     = 1'b1;
      s_data   = '0;
      s_valid  = 1'b0;
      s_last   = 1'b0;
      op_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_s_ready", 32'(s_ready), 32'd0);
      check("rst_op_valid", 32'(op_valid), 32'd0);
      check("rst_frame_err", 32'(frame_err), 32'd0);
      check("rst_alpha", alpha, 32'd0);
      check("rst_a23", a_m[2][3], 32'd0);
      irst = 1'b0;
      @(negedge clk);
      check("post_rst_s_ready", 32'(s_ready), 32'd1);

      send_frame(32'd1, 50, 50, 1'b0);
      check("op_valid", 32'(op_valid), 32'd1);
      check("a23", a_m[2][3], 32'd11);
      check("b11", b_m[1][1], 32'd1);
      check("frame_err", 32'(frame_err), 32'd0);
      check("hold_s_ready", 32'(s_ready), 32'd0);
      check_frame(32'd1);

      s_valid = 1'b1;
      s_data  = 32'd99;
      repeat (8) begin
         @(negedge clk);
         check("hold_valid", 32'(op_valid), 32'd1);
         check("hold_ready", 32'(s_ready), 32'd0);
         check("hold_a23", a_m[2][3], 32'd11);
         check("hold_alpha", alpha, 32'd1);
      end
      s_valid = 1'b0;
      release_hold();
      check("rel_alpha", alpha, 32'd1);

      send_frame(32'd7, 50, 50, 1'b1);
      check("gap_op_valid", 32'(op_valid), 32'd1);
      check_frame(32'd7);
      release_hold();

      send_frame(32'd5, 30, 0, 1'b0);
      irst = 1'b1;
      @(negedge clk);
      check("mid_rst_alpha", alpha, 32'd0);
      check("mid_rst_beta", beta, 32'd0);
      check("mid_rst_a23", a_m[2][3], 32'd0);
      check("mid_rst_b11", b_m[1][1], 32'd0);
      check("mid_rst_op_valid", 32'(op_valid), 32'd0);
      check("mid_rst_s_ready", 32'(s_ready), 32'd0);
      irst = 1'b0;
      @(negedge clk);
      check("mid_rst_ready_up", 32'(s_ready), 32'd1);
      send_frame(32'd3, 50, 50, 1'b0);
      check("reload_op_valid", 32'(op_valid), 32'd1);
      check_frame(32'd3);
      release_hold();

`ifdef GEMM_LOADER_LAST_CHECK_EN
      send_frame(32'd4, 20, 20, 1'b0);
      check("early_err", 32'(frame_err), 32'd1);
      check("early_no_valid", 32'(op_valid), 32'd0);
      check("early_ready", 32'(s_ready), 32'd1);
      send_frame(32'd9, 50, 50, 1'b0);
      check("after_early_valid", 32'(op_valid), 32'd1);
      check_frame(32'd9);
      check("err_sticky", 32'(frame_err), 32'd1);
      release_hold();
      send_frame(32'd6, 53, 53, 1'b0);
      check("drain_done_valid", 32'(op_valid), 32'd0);
      check("drain_done_ready", 32'(s_ready), 32'd1);
      check("drain_err", 32'(frame_err), 32'd1);
      send_frame(32'd2, 50, 50, 1'b0);
      check("after_drain_valid", 32'(op_valid), 32'd1);
      check_frame(32'd2);
      release_hold();
`endif

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule

// File: doc/gemm_operand_loader.md
GEMM_OPERAND_LOADER -- requirements
Module: gemm_operand_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand word width.
REQ-002 SHALL have parameter MATRIX_WIDTH, default 4, matrix columns.
REQ-003 SHALL have parameter MATRIX_HEIGHT, default 4, matrix rows.
REQ-004 SHALL have port iclk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port irst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port s_data  input  DATA_WIDTH  inbound operand word.
REQ-007 SHALL have port s_valid  input  1  s_data valid.
REQ-008 SHALL have port s_ready  output  1  loader accepts word.
REQ-009 SHALL have port s_last  input  1  final word of frame.
REQ-010 SHALL have ports alpha, beta  output  DATA_WIDTH each  scalars to gemm_top.
REQ-011 SHALL have ports a_matrix, b_matrix, c_matrix  output  unpacked [0:MATRIX_HEIGHT-1][0:MATRIX_WIDTH-1] of DATA_WIDTH  operands to gemm_top.
REQ-012 SHALL have port op_valid  output  1  complete operand set presented.
REQ-013 SHALL have port op_ready  input  1  consumer takes operand set.
REQ-014 SHALL have port frame_err  output  1  sticky framing-error flag.

Function
REQ-015 SHALL accept a word only on a cycle with s_valid and s_ready both high.
REQ-016 SHALL expect frame order: alpha, beta, A, B, C; each matrix row-major; N = 2 + 3*MATRIX_WIDTH*MATRIX_HEIGHT words (50 at defaults).
REQ-017 SHALL use states LD_ALPHA, LD_BETA, LD_A, LD_B, LD_C, HOLD, DRAIN.
REQ-018 SHALL advance LD_ALPHA->LD_BETA->LD_A on each accepted word, and LD_A->LD_B->LD_C when the element counter reaches MATRIX_WIDTH*MATRIX_HEIGHT-1, the counter wrapping to 0.
REQ-019 SHALL write an accepted matrix word to element [idx / MATRIX_WIDTH][idx % MATRIX_WIDTH] of the current matrix.
REQ-020 SHALL enter HOLD on acceptance of the final C word and assert op_valid on the following cycle.
REQ-021 SHALL hold op_valid and all operand outputs stable in HOLD until op_ready is high, then go to LD_ALPHA on the next cycle.
REQ-022 SHALL drive s_ready low in HOLD and high in all other states.
REQ-023 SHALL keep operand outputs unchanged during loading except the element being written.
REQ-024 SHALL ignore op_ready outside HOLD.

Reset
REQ-025 SHALL, while irst is high, force state LD_ALPHA, counter 0, s_ready 0, op_valid 0, frame_err 0, and alpha, beta and every matrix element to 0.
REQ-026 SHALL drive s_ready high on the first cycle after irst deasserts.
REQ-027 SHALL, on reset asserted mid-frame or in HOLD, discard the partial or pending frame.

Configuration
REQ-028 SHALL provide framing checks only when macro GEMM_LOADER_LAST_CHECK_EN is defined.
REQ-029 SHALL, with the macro defined and s_last high on any word before word N, set frame_err, discard the frame, and return to LD_ALPHA.
REQ-030 SHALL, with the macro defined and s_last low on word N, set frame_err, suppress op_valid, and enter DRAIN, accepting and discarding words until one with s_last high, then return to LD_ALPHA.
REQ-031 SHALL, without the macro, ignore s_last, tie frame_err to 0, and omit DRAIN logic.

Structure
REQ-032 SHALL take DATA_WIDTH, MATRIX_WIDTH and MATRIX_HEIGHT defaults and the loader state enum typedef from shared package gemm_pkg.
REQ-033 SHALL place the element index counter, with wrap and terminal-count output, in sub-module gemm_idx_counter.

Verification
REQ-034 SHALL cover: reset, then 50 words alpha=1, beta=1, A[i][j]=i*4+j, B=identity, C=0, with s_last on word 50 -> op_valid one cycle after word 50; a_matrix[2][3]=11; b_matrix[1][1]=1; frame_err=0.
REQ-035 SHALL cover: op_ready held low 8 cycles in HOLD -> op_valid and outputs stable; s_ready=0; LD_ALPHA and s_ready=1 one cycle after op_ready rises.
REQ-036 SHALL cover: s_valid toggled every other cycle across the frame -> same matrices as REQ-034, op_valid after 50 accepted words.
REQ-037 SHALL cover: macro defined, s_last on word 20 -> frame_err=1, no op_valid, next 50-word frame loads correctly.
REQ-038 SHALL cover: macro defined, no s_last on word 50, s_last on word 53 -> frame_err=1, no op_valid, 3 words drained, LD_ALPHA.
REQ-039 SHALL cover: irst pulsed after word 30 -> all outputs 0, next full frame loads correctly.
